// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the pipeline control blocks.
//   fwd_sel_t    : operand-forwarding mux select (RF / EX result / MEM result)
//   stage_info_t : per-stage destination and control summary carried alongside
//                  the pipeline registers
//   XZR          : index of the hard-wired zero register
package cpu_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic                 regwrite;
    logic                 memread;
    logic                 setflags;
  } stage_info_t;

  localparam stage_info_t STAGE_BUBBLE = '0;

endpackage

// File: rtl/fwd_hazard_ctrl_fwd_select.sv
// Per-operand forwarding comparator.
//   src_i  : source register index read by the ID-stage instruction
//   use_i  : instruction actually reads src_i
//   ex_i   : shadow info of the instruction in EX
//   mem_i  : shadow info of the instruction in MEM
//   sel_o  : FWD_EX / FWD_MEM / FWD_RF, EX taking priority as the younger value
module fwd_select
  import cpu_pkg::*;
#(
  parameter logic [REG_IDX_W-1:0] ZERO_REG = XZR
) (
  input  logic [REG_IDX_W-1:0] src_i,
  input  logic                 use_i,
  input  stage_info_t          ex_i,
  input  stage_info_t          mem_i,
  output fwd_sel_t             sel_o
);

  logic ex_hit;
  logic mem_hit;
  logic unused_fields;

  // A load in EX has no data yet; that case is the load-use hazard, not a forward.
  assign ex_hit  = use_i && ex_i.valid && ex_i.regwrite && !ex_i.memread &&
                   (ex_i.rd == src_i) && (src_i != ZERO_REG);
  assign mem_hit = use_i && mem_i.valid && mem_i.regwrite &&
                   (mem_i.rd == src_i) && (src_i != ZERO_REG);

  assign unused_fields = ^{ex_i.setflags, mem_i.memread, mem_i.setflags};

  always_comb begin
    sel_o = FWD_RF;
    if (ex_hit)       sel_o = FWD_EX;
    else if (mem_hit) sel_o = FWD_MEM;
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for the 5-stage LEGv8 pipeline.
// Tracks shadow EX/MEM destination info and produces:
//   fwd_a / fwd_b  : ID operand mux selects (00 RF, 01 EX, 10 MEM)
//   fwd_flags      : B.LT takes live EX flags instead of the flag register
//   stall          : load-use stall (hold PC and IF/ID, bubble into EX)
//   load_use_err   : load-use seen while stalling is disabled
//   stall_count    : saturating count of stall cycles
// Inputs are the decode-stage fields of the instruction currently in ID.
module fwd_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int                   REG_W          = REG_IDX_W,
  parameter logic [REG_W-1:0]     ZERO_REG       = XZR,
  parameter bit                   LOAD_USE_STALL = 1'b1,
  parameter int                   CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_setflags,
  input  logic             id_readflags,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             fwd_flags,
  output logic             stall,
  output logic             load_use_err,
  output logic [CNT_W-1:0] stall_count
);

  stage_info_t      ex_q, ex_d;
  stage_info_t      mem_q, mem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  fwd_sel_t         sel_a, sel_b;
  logic             lu_a, lu_b, lu;
  logic             stall_int;

  fwd_select #(.ZERO_REG(ZERO_REG)) u_fwd_a (
    .src_i (id_rn),
    .use_i (id_use_rn),
    .ex_i  (ex_q),
    .mem_i (mem_q),
    .sel_o (sel_a)
  );

  fwd_select #(.ZERO_REG(ZERO_REG)) u_fwd_b (
    .src_i (id_rm),
    .use_i (id_use_rm),
    .ex_i  (ex_q),
    .mem_i (mem_q),
    .sel_o (sel_b)
  );

  assign lu_a = id_use_rn && (ex_q.rd == id_rn);
  assign lu_b = id_use_rm && (ex_q.rd == id_rm);
  assign lu   = id_valid && ex_q.valid && ex_q.memread && (ex_q.rd != ZERO_REG) &&
                (lu_a || lu_b);

  assign stall_int = LOAD_USE_STALL && lu;

  always_comb begin
    ex_d  = STAGE_BUBBLE;
    mem_d = ex_q;
    cnt_d = cnt_q;
    if (id_valid && !stall_int) begin
      ex_d.valid    = 1'b1;
      ex_d.rd       = id_rd;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
      ex_d.setflags = id_setflags;
    end
    if (stall_int && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= STAGE_BUBBLE;
      mem_q <= STAGE_BUBBLE;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  // Everything is forced quiet during reset, including stale pre-reset state.
  always_comb begin
    fwd_a        = FWD_RF;
    fwd_b        = FWD_RF;
    fwd_flags    = 1'b0;
    stall        = 1'b0;
    load_use_err = 1'b0;
    if (!reset && id_valid) begin
      fwd_a     = sel_a;
      fwd_b     = sel_b;
      fwd_flags = id_readflags && ex_q.valid && ex_q.setflags;
      stall     = stall_int;
      if (!LOAD_USE_STALL) begin
        load_use_err = lu;
        // Without a stall the load data does not exist yet; an older MEM
        // match would be stale, so the offending operand reads the RF.
        if (lu && lu_a) fwd_a = FWD_RF;
        if (lu && lu_b) fwd_b = FWD_RF;
      end
    end
  end

  assign stall_count = reset ? '0 : cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_use_rn, id_use_rm, id_regwrite, id_memread;
  logic       id_setflags, id_readflags;
  logic [4:0] id_rn, id_rm, id_rd;

  logic [1:0] fa0, fb0, fa1, fb1;
  logic       ff0, st0, er0, ff1, st1, er1;
  logic [3:0] cnt0, cnt1;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.LOAD_USE_STALL(1'b1), .CNT_W(4)) u_stall (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_setflags(id_setflags),
    .id_readflags(id_readflags), .fwd_a(fa0), .fwd_b(fb0), .fwd_flags(ff0),
    .stall(st0), .load_use_err(er0), .stall_count(cnt0)
  );

  fwd_hazard_ctrl #(.LOAD_USE_STALL(1'b0), .CNT_W(4)) u_nostall (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_setflags(id_setflags),
    .id_readflags(id_readflags), .fwd_a(fa1), .fwd_b(fb1), .fwd_flags(ff1),
    .stall(st1), .load_use_err(er1), .stall_count(cnt1)
  );

  typedef struct {
    int         dut;
    string      tag;
    logic [1:0] a;
    logic [1:0] b;
    logic       f;
    logic       st;
    logic       er;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input string fld, input logic [3:0] obs,
                     input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, expv);
    end
  endtask

  task automatic compare_all();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.dut == 0) begin
        chk(e.tag, "fwd_a", {2'b00, fa0}, {2'b00, e.a});
        chk(e.tag, "fwd_b", {2'b00, fb0}, {2'b00, e.b});
        chk(e.tag, "fwd_flags", {3'b000, ff0}, {3'b000, e.f});
        chk(e.tag, "stall", {3'b000, st0}, {3'b000, e.st});
        chk(e.tag, "load_use_err", {3'b000, er0}, {3'b000, e.er});
        chk(e.tag, "stall_count", cnt0, e.cnt);
      end else begin
        chk(e.tag, "fwd_a", {2'b00, fa1}, {2'b00, e.a});
        chk(e.tag, "fwd_b", {2'b00, fb1}, {2'b00, e.b});
        chk(e.tag, "fwd_flags", {3'b000, ff1}, {3'b000, e.f});
        chk(e.tag, "stall", {3'b000, st1}, {3'b000, e.st});
        chk(e.tag, "load_use_err", {3'b000, er1}, {3'b000, e.er});
        chk(e.tag, "stall_count", cnt1, e.cnt);
      end
    end
  endtask

  task automatic push(input int dut, input string tag, input logic [1:0] a,
                      input logic [1:0] b, input logic f, input logic st,
                      input logic er, input logic [3:0] cnt);
    exp_t e;
    e.dut = dut; e.tag = tag; e.a = a; e.b = b; e.f = f; e.st = st; e.er = er;
    e.cnt = cnt;
    sb.push_back(e);
  endtask

  // Expectation for the stalling instance (load_use_err always 0 there).
  task automatic exp0(input string tag, input logic [1:0] a, input logic [1:0] b,
                      input logic f, input logic st, input logic [3:0] cnt);
    push(0, tag, a, b, f, st, 1'b0, cnt);
  endtask

  task automatic drive(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                       input logic urn, input logic urm, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic sf, input logic rf);
    id_valid = v; id_rn = rn; id_rm = rm; id_use_rn = urn; id_use_rm = urm;
    id_rd = rd; id_regwrite = rw; id_memread = mr; id_setflags = sf;
    id_readflags = rf;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic flush(input string tag, input logic [3:0] cnt);
    idle();
    exp0(tag, 2'b00, 2'b00, 1'b0, 1'b0, cnt); cycle();
    exp0(tag, 2'b00, 2'b00, 1'b0, 1'b0, cnt); cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    logic ex_st;
    logic [1:0] ex_a;
    logic [3:0] ex_cnt;

    // Reset with a hazard-shaped instruction in ID: outputs must stay quiet.
    reset = 1'b1;
    drive(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    exp0("reset0", 2'b00, 2'b00, 1'b0, 1'b0, 4'd0);
    push(1, "reset0_ns", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0);
    cycle();
    exp0("reset1", 2'b00, 2'b00, 1'b0, 1'b0, 4'd0);
    cycle();
    reset = 1'b0;

    // ADDS X1,X2,X3 ; SUBS X4,X1,X5
    drive(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    exp0("first_after_reset", 2'b00, 2'b00, 1'b0, 1'b0, 4'd0); cycle();
    drive(1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    exp0("ex_fwd_a", 2'b01, 2'b00, 1'b0, 1'b0, 4'd0); cycle();
    flush("flush1", 4'd0);

    // ADDI X1,X1,#1 ; NOP ; STUR X1,[X2]
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    exp0("addi", 2'b00, 2'b00, 1'b0, 1'b0, 4'd0); cycle();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp0("nop", 2'b00, 2'b00, 1'b0, 1'b0, 4'd0); cycle();
    drive(1'b1, 5'd2, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp0("mem_fwd_b", 2'b00, 2'b10, 1'b0, 1'b0, 4'd0); cycle();
    flush("flush2", 4'd0);

    // ADDI X1 ; ADD X1,X3,X4 ; STUR X1 -> EX wins over MEM
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    exp0("addi2", 2'b00, 2'b00, 1'b0, 1'b0, 4'd0); cycle();
    drive(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    exp0("add_x1", 2'b00, 2'b00, 1'b0, 1'b0, 4'd0); cycle();
    drive(1'b1, 5'd2, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp0("ex_priority_b", 2'b00, 2'b01, 1'b0, 1'b0, 4'd0); cycle();
    flush("flush3", 4'd0);

    // LDUR X7,[X0] ; ADDS X8,X7,X7 -> one stall then MEM forward
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    exp0("ldur", 2'b00, 2'b00, 1'b0, 1'b0, 4'd0); cycle();
    drive(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0);
    exp0("lu_stall", 2'b00, 2'b00, 1'b0, 1'b1, 4'd0); cycle();
    exp0("lu_release", 2'b10, 2'b10, 1'b0, 1'b0, 4'd1); cycle();
    flush("flush4", 4'd1);

    // XZR is never a forwarding or hazard source
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0);
    exp0("addi_xzr", 2'b00, 2'b00, 1'b0, 1'b0, 4'd1); cycle();
    drive(1'b1, 5'd31, 5'd31, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    exp0("xzr_no_fwd", 2'b00, 2'b00, 1'b0, 1'b0, 4'd1); cycle();
    flush("flush5", 4'd1);
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0);
    exp0("ldur_xzr", 2'b00, 2'b00, 1'b0, 1'b0, 4'd1); cycle();
    drive(1'b1, 5'd31, 5'd31, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    exp0("xzr_no_stall", 2'b00, 2'b00, 1'b0, 1'b0, 4'd1); cycle();
    flush("flush6", 4'd1);

    // Flag forwarding
    drive(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    exp0("subs", 2'b00, 2'b00, 1'b0, 1'b0, 4'd1); cycle();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp0("blt_fwd", 2'b00, 2'b00, 1'b1, 1'b0, 4'd1); cycle();
    flush("flush7", 4'd1);
    drive(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    exp0("subs2", 2'b00, 2'b00, 1'b0, 1'b0, 4'd1); cycle();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp0("nop2", 2'b00, 2'b00, 1'b0, 1'b0, 4'd1); cycle();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp0("blt_no_fwd", 2'b00, 2'b00, 1'b0, 1'b0, 4'd1); cycle();
    flush("flush8", 4'd1);
    drive(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    exp0("subs3", 2'b00, 2'b00, 1'b0, 1'b0, 4'd1); cycle();
    drive(1'b0, 5'd1, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp0("invalid_id_quiet", 2'b00, 2'b00, 1'b0, 1'b0, 4'd1); cycle();
    flush("flush9", 4'd1);

    // Reset asserted during a stall cycle
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    exp0("ldur_r", 2'b00, 2'b00, 1'b0, 1'b0, 4'd1); cycle();
    drive(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0);
    exp0("stall_before_reset", 2'b00, 2'b00, 1'b0, 1'b1, 4'd1);
    @(negedge clk);
    compare_all();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp0("after_reset_mid_stall", 2'b00, 2'b00, 1'b0, 1'b0, 4'd0); cycle();
    flush("flush10", 4'd0);

    // LDUR X7,[X7] held in ID: stalls every other cycle until saturation
    drive(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    stalls = 0;
    for (int i = 0; i <= 40; i++) begin
      ex_st  = (i % 2 == 1);
      ex_a   = (i >= 2 && i % 2 == 0) ? 2'b10 : 2'b00;
      ex_cnt = (stalls > 15) ? 4'd15 : 4'(stalls);
      exp0($sformatf("sat_%0d", i), ex_a, 2'b00, 1'b0, ex_st, ex_cnt);
      cycle();
      if (ex_st) stalls++;
    end
    flush("sat_hold", 4'd15);

    // Non-stalling instance: ADD X7 ; LDUR X7 ; ADDS X8,X7,X7
    reset = 1'b1;
    idle();
    push(1, "ns_reset", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0); cycle();
    reset = 1'b0;
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    push(1, "ns_add", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0); cycle();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    push(1, "ns_ldur", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0); cycle();
    drive(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0);
    push(1, "ns_load_use_err", 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 4'd0); cycle();
    idle();
    push(1, "ns_after", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0); cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
